// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge port.
//   imemReq   fetch request, held until acknowledged or abandoned
//   imemAddr  word address being fetched
//   imemAck   memory presents imemData in this cycle
//   imemData  fetched instruction word
// master: fetch unit side, slave: memory side.
interface instr_fetch_unit_if;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemAck;
   logic [31:0] imemData;

   modport master (output imemReq, output imemAddr, input imemAck, input imemData);
   modport slave  (input imemReq, input imemAddr, output imemAck, output imemData);
endinterface

// File: rtl/instr_fetch_unit.sv
// MIPS32 instruction fetch front end. Holds the PC, fetches one instruction
// at a time over the imem port, presents decode fields and computes the next
// PC from the decoder's jump/branch controls when the instruction retires.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   imem (master)              imemReq/imemAddr out, imemAck/imemData in
//   instr, opc, func,
//   bgez_bltz, instrValid      instruction register and decode fields
//   pc, pcPlus4                address of instr and its sequential successor
//   exDone                     execute stage retires instr this cycle
//   isJmp, isJal, isJr, branch,
//   invOpcode                  decoder controls
//   aluZero, rsNeg, rsZero,
//   rsData                     operand flags / JR target
//   fault, faultCode           halt indication: 01 opcode, 10 JR align, 11 timeout
//
// state  | meaning
// FETCH  | one cycle, raise imemReq
// WAIT   | request outstanding, count toward timeout
// EXEC   | instr live, wait for exDone
// HALT   | faulted, idle until reset
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC      = 32'h0040_0000,
   parameter int          FETCH_TIMEOUT = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   instr_fetch_unit_if.master         imem,
   output logic [31:0]                instr,
   output logic [5:0]                 opc,
   output logic [5:0]                 func,
   output logic [4:0]                 bgez_bltz,
   output logic                       instrValid,
   output logic [31:0]                pc,
   output logic [31:0]                pcPlus4,
   input  logic                       exDone,
   input  logic                       isJmp,
   input  logic                       isJal,
   input  logic                       isJr,
   input  logic [2:0]                 branch,
   input  logic                       invOpcode,
   input  logic                       aluZero,
   input  logic                       rsNeg,
   input  logic                       rsZero,
   input  logic [31:0]                rsData,
   output logic                       fault,
   output logic [1:0]                 faultCode
);

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_EXEC  = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

   localparam int CW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;

   logic [1:0]    state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   instr_q, instr_d;
   logic          valid_q, valid_d;
   logic          req_q, req_d;
   logic          fault_q, fault_d;
   logic [1:0]    code_q, code_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [31:0]   pc_plus4;
   logic [31:0]   jmp_tgt;
   logic [31:0]   br_tgt;
   logic          br_taken;
   logic          timeout_hit;

   assign pc_plus4    = pc_q + 32'd4;
   assign jmp_tgt     = {pc_plus4[31:28], instr_q[25:0], 2'b00};
   assign br_tgt      = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
   // A zero timeout disables the fault entirely; the counter then just wraps.
   assign timeout_hit = (FETCH_TIMEOUT != 0) && (cnt_q == CW'(FETCH_TIMEOUT - 1));

   always_comb begin
      br_taken = 1'b0;
      case (branch)
         3'd1:    br_taken = aluZero;
         3'd2:    br_taken = !aluZero;
         3'd3:    br_taken = !rsNeg;
         3'd4:    br_taken = !rsNeg && !rsZero;
         3'd5:    br_taken = rsNeg || rsZero;
         3'd6:    br_taken = rsNeg;
         default: br_taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      req_d   = req_q;
      fault_d = fault_q;
      code_d  = code_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_FETCH: begin
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // ack takes priority over a coincident timeout
            if (imem.imemAck) begin
               instr_d = imem.imemData;
               valid_d = 1'b1;
               req_d   = 1'b0;
               cnt_d   = '0;
               state_d = S_EXEC;
            end else if (timeout_hit) begin
               req_d   = 1'b0;
               fault_d = 1'b1;
               code_d  = 2'b11;
               cnt_d   = '0;
               state_d = S_HALT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_EXEC: begin
            if (exDone) begin
               valid_d = 1'b0;
               if (invOpcode) begin
                  fault_d = 1'b1;
                  code_d  = 2'b01;
                  state_d = S_HALT;
               end else if (isJr && (rsData[1:0] != 2'b00)) begin
                  fault_d = 1'b1;
                  code_d  = 2'b10;
                  state_d = S_HALT;
               end else begin
                  if (isJr)                pc_d = rsData;
                  else if (isJmp || isJal) pc_d = jmp_tgt;
                  else if (br_taken)       pc_d = br_tgt;
                  else                     pc_d = pc_plus4;
                  state_d = S_FETCH;
               end
            end
         end
         S_HALT: begin
            req_d   = 1'b0;
            valid_d = 1'b0;
         end
         default: state_d = S_HALT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         valid_q <= 1'b0;
         req_q   <= 1'b0;
         fault_q <= 1'b0;
         code_q  <= 2'b00;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         req_q   <= req_d;
         fault_q <= fault_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
      end
   end

   assign imem.imemReq  = req_q;
   assign imem.imemAddr = pc_q;
   assign instr         = instr_q;
   assign opc           = instr_q[31:26];
   assign func          = instr_q[5:0];
   assign bgez_bltz     = instr_q[20:16];
   assign instrValid    = valid_q;
   assign pc            = pc_q;
   assign pcPlus4       = pc_plus4;
   assign fault         = fault_q;
   assign faultCode     = code_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: drives memory and execute-stage behaviour,
// keeps a transaction-level model of pc/instr/fault and compares every cycle.
module tb_instr_fetch_unit;
   localparam logic [31:0] RST_PC = 32'h0040_0000;
   localparam int          TMO    = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        exDone, isJmp, isJal, isJr, invOpcode, aluZero, rsNeg, rsZero;
   logic [2:0]  branch;
   logic [31:0] rsData;
   logic [31:0] instr, pc, pcPlus4;
   logic [5:0]  opc, func;
   logic [4:0]  bgez_bltz;
   logic        instrValid, fault;
   logic [1:0]  faultCode;

   instr_fetch_unit_if imem();

   instr_fetch_unit #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .imem(imem),
      .instr(instr), .opc(opc), .func(func), .bgez_bltz(bgez_bltz),
      .instrValid(instrValid), .pc(pc), .pcPlus4(pcPlus4),
      .exDone(exDone), .isJmp(isJmp), .isJal(isJal), .isJr(isJr),
      .branch(branch), .invOpcode(invOpcode), .aluZero(aluZero),
      .rsNeg(rsNeg), .rsZero(rsZero), .rsData(rsData),
      .fault(fault), .faultCode(faultCode)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   // model
   logic [31:0] m_pc, m_instr;
   bit          m_req, m_valid, m_fault;
   logic [1:0]  m_code;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk32("imemReq",    32'(imem.imemReq), 32'(m_req));
         chk32("imemAddr",   imem.imemAddr, m_pc);
         chk32("pc",         pc, m_pc);
         chk32("pcPlus4",    pcPlus4, m_pc + 32'd4);
         chk32("instrValid", 32'(instrValid), 32'(m_valid));
         chk32("instr",      instr, m_instr);
         chk32("opc",        32'(opc), 32'(m_instr[31:26]));
         chk32("func",       32'(func), 32'(m_instr[5:0]));
         chk32("bgez_bltz",  32'(bgez_bltz), 32'(m_instr[20:16]));
         chk32("fault",      32'(fault), 32'(m_fault));
         chk32("faultCode",  32'(faultCode), 32'(m_code));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic m_reset();
      m_pc = RST_PC; m_instr = '0; m_req = 0; m_valid = 0; m_fault = 0; m_code = 2'b00;
   endtask

   function automatic logic [31:0] model_next();
      logic [31:0] p4;
      bit take;
      p4 = m_pc + 32'd4;
      if (isJr) return rsData;
      if (isJmp || isJal) return {p4[31:28], m_instr[25:0], 2'b00};
      case (branch)
         3'd1:    take = aluZero;
         3'd2:    take = !aluZero;
         3'd3:    take = !rsNeg;
         3'd4:    take = !rsNeg && !rsZero;
         3'd5:    take = rsNeg || rsZero;
         3'd6:    take = rsNeg;
         default: take = 0;
      endcase
      if (take) return p4 + (32'($signed(m_instr[15:0])) << 2);
      return p4;
   endfunction

   task automatic set_ctl(input bit j, input bit jal, input bit jr, input logic [2:0] br,
                          input bit inv, input bit z, input bit ng, input bit rz,
                          input logic [31:0] rs);
      isJmp = j; isJal = jal; isJr = jr; branch = br; invOpcode = inv;
      aluZero = z; rsNeg = ng; rsZero = rz; rsData = rs;
   endtask

   task automatic rand_ctl();
      set_ctl(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), $urandom);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk32("async_req_drop", 32'(imem.imemReq), 32'd0);
      m_reset();
      step();
      rst_n = 1'b1;
   endtask

   // Starts in FETCH; one edge raises req, then `delay` edges without ack.
   task automatic do_fetch(input logic [31:0] word, input int delay, input bit stray);
      imem.imemAck  = stray;
      imem.imemData = $urandom;
      step();
      imem.imemAck = 1'b0;
      m_req = 1;
      repeat (delay) begin
         imem.imemData = $urandom;
         step();
      end
      imem.imemAck  = 1'b1;
      imem.imemData = word;
      step();
      imem.imemAck = 1'b0;
      m_req = 0; m_valid = 1; m_instr = word;
   endtask

   task automatic do_timeout();
      imem.imemAck = 1'b0;
      step();
      m_req = 1;
      repeat (TMO) step();
      m_req = 0; m_fault = 1; m_code = 2'b11;
   endtask

   task automatic idle(input int n);
      logic [31:0] s_rs;
      logic [2:0]  s_br;
      bit s_j, s_jal, s_jr, s_inv, s_z, s_ng, s_rz;
      s_j = isJmp; s_jal = isJal; s_jr = isJr; s_br = branch; s_inv = invOpcode;
      s_z = aluZero; s_ng = rsNeg; s_rz = rsZero; s_rs = rsData;
      exDone = 1'b0;
      repeat (n) begin
         rand_ctl();
         step();
      end
      set_ctl(s_j, s_jal, s_jr, s_br, s_inv, s_z, s_ng, s_rz, s_rs);
   endtask

   task automatic retire();
      logic [31:0] nxt;
      nxt = model_next();
      exDone = 1'b1;
      step();
      exDone = 1'b0;
      m_valid = 0;
      if (invOpcode) begin
         m_fault = 1; m_code = 2'b01;
      end else if (isJr && rsData[1:0] != 2'b00) begin
         m_fault = 1; m_code = 2'b10;
      end else begin
         m_pc = nxt;
      end
   endtask

   task automatic halt_soak(input int n);
      repeat (n) begin
         imem.imemAck  = 1'($urandom);
         imem.imemData = $urandom;
         exDone        = 1'($urandom);
         rand_ctl();
         step();
      end
      imem.imemAck = 1'b0;
      exDone       = 1'b0;
   endtask

   localparam logic [31:0] NOP = 32'h2008_0005;

   initial begin
      rst_n = 1'b1;
      exDone = 1'b0;
      imem.imemAck = 1'b0;
      imem.imemData = '0;
      set_ctl(0, 0, 0, 3'd0, 0, 0, 0, 0, 32'h0);
      m_reset();
      #2 rst_n = 1'b0;
      step();
      chk_en = 1'b1;
      step();
      rst_n = 1'b1;

      // T1: zero-wait fetch and sequential retire
      chk32("t1_reset_addr", imem.imemAddr, 32'h0040_0000);
      do_fetch(NOP, 0, 0);
      chk32("t1_valid", 32'(instrValid), 32'd1);
      chk32("t1_opc", 32'(opc), 32'h08);
      idle(2);
      retire();
      chk32("t1_pc", pc, 32'h0040_0004);

      // T2: beq with imm -1, taken then not taken
      for (int i = 0; i < 3; i++) begin
         do_fetch(NOP, $urandom_range(0, 3), 0);
         retire();
      end
      chk32("t2_at_beq", pc, 32'h0040_0010);
      do_fetch(32'h1000_FFFF, 1, 0);
      set_ctl(0, 0, 0, 3'd1, 0, 1, 0, 0, 32'h0);
      retire();
      chk32("t2_beq_taken", pc, 32'h0040_0010);
      do_fetch(32'h1000_FFFF, 0, 0);
      set_ctl(0, 0, 0, 3'd1, 0, 0, 0, 0, 32'h0);
      retire();
      chk32("t2_beq_not_taken", pc, 32'h0040_0014);

      // T3: jal then misaligned jr
      do_reset();
      do_fetch(32'h0C10_0008, 0, 0);
      chk32("t3_pcPlus4", pcPlus4, 32'h0040_0004);
      set_ctl(0, 1, 0, 3'd0, 0, 0, 0, 0, 32'h0);
      retire();
      chk32("t3_jal_pc", pc, 32'h0040_0020);
      do_fetch(32'h03E0_0008, 2, 0);
      set_ctl(0, 0, 1, 3'd0, 0, 0, 0, 0, 32'h0040_0102);
      retire();
      chk32("t3_jr_fault", 32'(fault), 32'd1);
      chk32("t3_jr_code", 32'(faultCode), 32'd2);
      halt_soak(5);

      // T4: ack in last allowed cycle, then timeout
      do_reset();
      set_ctl(0, 0, 0, 3'd0, 0, 0, 0, 0, 32'h0);
      do_fetch(NOP, TMO - 1, 0);
      chk32("t4_late_ack_valid", 32'(instrValid), 32'd1);
      retire();
      do_timeout();
      chk32("t4_fault", 32'(fault), 32'd1);
      chk32("t4_code", 32'(faultCode), 32'd3);
      chk32("t4_req", 32'(imem.imemReq), 32'd0);
      halt_soak(4);

      // T5: invalid opcode halts with pc held
      do_reset();
      do_fetch(32'hFC00_0000, 2, 0);
      set_ctl(0, 0, 0, 3'd0, 1, 0, 0, 0, 32'h0);
      retire();
      chk32("t5_code", 32'(faultCode), 32'd1);
      halt_soak(10);
      chk32("t5_pc_held", pc, 32'h0040_0000);

      // T6: reset while request outstanding, stray ack after release
      do_reset();
      set_ctl(0, 0, 0, 3'd0, 0, 0, 0, 0, 32'h0);
      do_fetch(NOP, 0, 0);
      retire();
      imem.imemAck = 1'b0;
      step();
      m_req = 1;
      chk32("t6_req_before", 32'(imem.imemReq), 32'd1);
      do_reset();
      do_fetch(32'h2009_0001, 1, 1);
      chk32("t6_refetch_instr", instr, 32'h2009_0001);
      chk32("t6_refetch_pc", pc, RST_PC);

      // PC wrap
      set_ctl(0, 0, 1, 3'd0, 0, 0, 0, 0, 32'hFFFF_FFFC);
      retire();
      do_fetch(NOP, 0, 0);
      set_ctl(0, 0, 0, 3'd0, 0, 0, 0, 0, 32'h0);
      retire();
      chk32("wrap_pc", pc, 32'h0000_0000);
      chk32("wrap_fault", 32'(fault), 32'd0);

      // randomized traffic
      repeat (150) begin
         do_fetch($urandom, $urandom_range(0, TMO - 1), 1'($urandom));
         idle($urandom_range(0, 4));
         case ($urandom_range(0, 4))
            0: set_ctl(0, 0, 0, 3'd0, 0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
            1: set_ctl(1, 0, 0, 3'($urandom), 0, 0, 0, 0, $urandom);
            2: set_ctl(0, 1, 0, 3'($urandom), 0, 0, 0, 0, $urandom);
            3: set_ctl(0, 0, 1, 3'($urandom), 0, 0, 0, 0, $urandom & 32'hFFFF_FFFC);
            default: set_ctl(0, 0, 0, 3'($urandom), 0, 1'($urandom), 1'($urandom),
                             1'($urandom), $urandom);
         endcase
         retire();
      end
      chk32("rand_no_fault", 32'(fault), 32'd0);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
